// File: rtl/window_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : window_frame_sequencer
//  Purpose  : Registers the pixel stream into the sliding-window generator and
//             appends synthetic pad lines at frame end so the last rows drain.
//  Revision : 1.0 - initial release
// ============================================================================
module window_frame_sequencer #(
    parameter int PX_WIDTH      = 12,
    parameter int PX_PER_CLK    = 4,
    parameter int MAX_LINE_SIZE = 4112,
    parameter int FLUSH_LINES   = 1,
    parameter int LINE_GAP      = 4,
    parameter int PAD_VALUE     = 0,
    localparam int LW_W         = $clog2(MAX_LINE_SIZE / PX_PER_CLK + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_i,
    input  logic [PX_PER_CLK-1:0]          px_data_val_i,
    input  logic                           line_start_i,
    input  logic                           line_end_i,
    input  logic                           frame_start_i,
    input  logic                           frame_end_i,
    output logic                           in_ready_o,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic [LW_W-1:0]                line_words_o,
    output logic [15:0]                    line_cnt_o,
    output logic                           frame_done_o,
    output logic                           err_o
);

    localparam int GAP_W = $clog2(LINE_GAP + 2);
    localparam int FL_W  = $clog2(FLUSH_LINES + 2);
    localparam logic [GAP_W-1:0]      c_gap_last = GAP_W'(LINE_GAP);
    localparam logic [FL_W-1:0]       c_fl_last  = FL_W'((FLUSH_LINES == 0) ? 0 : FLUSH_LINES - 1);
    localparam logic [PX_PER_CLK-1:0] c_all_val  = '1;
    localparam logic [PX_WIDTH-1:0]   c_pad_px   = PX_WIDTH'(PAD_VALUE);
    localparam bit                    c_do_flush = (FLUSH_LINES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                         r_state, w_nxt_state;
    logic                           r_in_ready, w_nxt_in_ready;
    logic [PX_PER_CLK*PX_WIDTH-1:0] r_px_data, w_nxt_px_data;
    logic [PX_PER_CLK-1:0]          r_px_val, w_nxt_px_val;
    logic                           r_ls, w_nxt_ls;
    logic                           r_le, w_nxt_le;
    logic                           r_fs, w_nxt_fs;
    logic                           r_fe, w_nxt_fe;
    logic                           r_done, w_nxt_done;
    logic                           r_err, w_nxt_err;
    logic [LW_W-1:0]                r_line_words, w_nxt_line_words;
    logic [15:0]                    r_line_cnt, w_nxt_line_cnt;
    logic [LW_W-1:0]                r_word_cnt, w_nxt_word_cnt;
    logic [PX_PER_CLK-1:0]          r_last_mask, w_nxt_last_mask;
    logic                           r_measured, w_nxt_measured;
    logic [GAP_W-1:0]               r_gap_cnt, w_nxt_gap_cnt;
    logic [LW_W-1:0]                r_pad_word, w_nxt_pad_word;
    logic [FL_W-1:0]                r_pad_line, w_nxt_pad_line;

    logic            w_any_val;
    logic            w_accept;
    logic            w_take;
    logic            w_last_pad;
    logic [LW_W-1:0] w_cur_words;
    logic [15:0]     w_cnt_base;
    logic [15:0]     w_cnt_inc;
    logic [LW_W-1:0] w_pad_last_word;

    assign w_any_val   = |px_data_val_i;
    assign w_accept    = r_in_ready && w_any_val;
    assign w_cur_words = line_start_i ? LW_W'(1) : r_word_cnt + LW_W'(1);
    assign w_cnt_base  = frame_start_i ? 16'd0 : r_line_cnt;
    assign w_cnt_inc   = (w_cnt_base == 16'hFFFF) ? w_cnt_base : w_cnt_base + 16'd1;
    // A never-measured frame still produces one pad word per line rather than none.
    assign w_pad_last_word = (r_line_words == '0) ? '0 : r_line_words - LW_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_px_data    = '0;
        w_nxt_px_val     = '0;
        w_nxt_ls         = 1'b0;
        w_nxt_le         = 1'b0;
        w_nxt_fs         = 1'b0;
        w_nxt_fe         = 1'b0;
        w_nxt_done       = 1'b0;
        w_nxt_err        = w_any_val && !r_in_ready;
        w_nxt_line_words = r_line_words;
        w_nxt_line_cnt   = r_line_cnt;
        w_nxt_word_cnt   = r_word_cnt;
        w_nxt_last_mask  = r_last_mask;
        w_nxt_measured   = r_measured;
        w_nxt_gap_cnt    = r_gap_cnt;
        w_nxt_pad_word   = r_pad_word;
        w_nxt_pad_line   = r_pad_line;
        w_take           = 1'b0;
        w_last_pad       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (frame_start_i && line_start_i) begin
                        w_take      = 1'b1;
                        w_nxt_state = S_PASS;
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
            end
            S_PASS: begin
                if (w_accept) begin
                    w_take = 1'b1;
                    if (frame_start_i) begin
                        w_nxt_err = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (r_gap_cnt != c_gap_last) begin
                    w_nxt_gap_cnt = r_gap_cnt + GAP_W'(1);
                end else begin
                    w_nxt_px_data = {PX_PER_CLK{c_pad_px}};
                    w_nxt_ls      = (r_pad_word == '0);
                    if (r_pad_word == w_pad_last_word) begin
                        w_nxt_px_val   = r_last_mask;
                        w_nxt_le       = 1'b1;
                        w_nxt_pad_word = '0;
                        w_nxt_gap_cnt  = '0;
                        if (r_pad_line == c_fl_last) begin
                            w_nxt_fe    = 1'b1;
                            w_nxt_done  = 1'b1;
                            w_last_pad  = 1'b1;
                            w_nxt_state = S_IDLE;
                        end else begin
                            w_nxt_pad_line = r_pad_line + FL_W'(1);
                        end
                    end else begin
                        w_nxt_px_val   = c_all_val;
                        w_nxt_pad_word = r_pad_word + LW_W'(1);
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        if (w_take) begin
            w_nxt_px_data  = px_data_i;
            w_nxt_px_val   = px_data_val_i;
            w_nxt_ls       = line_start_i;
            w_nxt_le       = line_end_i;
            w_nxt_fs       = frame_start_i;
            w_nxt_word_cnt = w_cur_words;
            if (frame_start_i) begin
                w_nxt_measured = 1'b0;
                w_nxt_line_cnt = '0;
            end
            if (line_end_i) begin
                w_nxt_line_cnt = w_cnt_inc;
                // Only the first line of a frame sets the pad line geometry.
                if (!r_measured || frame_start_i) begin
                    w_nxt_line_words = w_cur_words;
                    w_nxt_last_mask  = px_data_val_i;
                    w_nxt_measured   = 1'b1;
                end
            end
            if (frame_end_i) begin
                if (!line_end_i) begin
                    w_nxt_err = 1'b1;
                end
                if (c_do_flush) begin
                    w_nxt_state    = S_FLUSH;
                    w_nxt_gap_cnt  = '0;
                    w_nxt_pad_word = '0;
                    w_nxt_pad_line = '0;
                end else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_fe    = 1'b1;
                    w_nxt_done  = 1'b1;
                end
            end
        end

        // Hold the source off until the final pad word has left the output stage.
        w_nxt_in_ready = (w_nxt_state != S_FLUSH) && !w_last_pad;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in_ready   <= 1'b1;
            r_px_data    <= '0;
            r_px_val     <= '0;
            r_ls         <= 1'b0;
            r_le         <= 1'b0;
            r_fs         <= 1'b0;
            r_fe         <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_line_words <= '0;
            r_line_cnt   <= '0;
            r_word_cnt   <= '0;
            r_last_mask  <= '0;
            r_measured   <= 1'b0;
            r_gap_cnt    <= '0;
            r_pad_word   <= '0;
            r_pad_line   <= '0;
        end else begin
            r_in_ready   <= w_nxt_in_ready;
            r_px_data    <= w_nxt_px_data;
            r_px_val     <= w_nxt_px_val;
            r_ls         <= w_nxt_ls;
            r_le         <= w_nxt_le;
            r_fs         <= w_nxt_fs;
            r_fe         <= w_nxt_fe;
            r_done       <= w_nxt_done;
            r_err        <= w_nxt_err;
            r_line_words <= w_nxt_line_words;
            r_line_cnt   <= w_nxt_line_cnt;
            r_word_cnt   <= w_nxt_word_cnt;
            r_last_mask  <= w_nxt_last_mask;
            r_measured   <= w_nxt_measured;
            r_gap_cnt    <= w_nxt_gap_cnt;
            r_pad_word   <= w_nxt_pad_word;
            r_pad_line   <= w_nxt_pad_line;
        end
    end

    assign in_ready_o    = r_in_ready;
    assign px_data_o     = r_px_data;
    assign px_data_val_o = r_px_val;
    assign line_start_o  = r_ls;
    assign line_end_o    = r_le;
    assign frame_start_o = r_fs;
    assign frame_end_o   = r_fe;
    assign line_words_o  = r_line_words;
    assign line_cnt_o    = r_line_cnt;
    assign frame_done_o  = r_done;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_window_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_window_frame_sequencer
//  Purpose  : Directed self-checking bench; three instances cover flush depths
//             of 0, 1 and 2 pad lines driven from one shared input stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_frame_sequencer;

    localparam int LWW = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] px_data = '0;
    logic [3:0]  px_val = '0;
    logic        ls = 1'b0, le = 1'b0, fs = 1'b0, fe = 1'b0;

    logic        rdy0, rdy1, rdy2;
    logic [47:0] dat0, dat1, dat2;
    logic [3:0]  val0, val1, val2;
    logic        ls0, ls1, ls2, le0, le1, le2, fs0, fs1, fs2, fe0, fe1, fe2;
    logic [LWW-1:0] lw0, lw1, lw2;
    logic [15:0] lc0, lc1, lc2;
    logic        done0, done1, done2, err0, err1, err2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    window_frame_sequencer #(.FLUSH_LINES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .px_data_i(px_data), .px_data_val_i(px_val),
        .line_start_i(ls), .line_end_i(le), .frame_start_i(fs), .frame_end_i(fe),
        .in_ready_o(rdy0), .px_data_o(dat0), .px_data_val_o(val0),
        .line_start_o(ls0), .line_end_o(le0), .frame_start_o(fs0), .frame_end_o(fe0),
        .line_words_o(lw0), .line_cnt_o(lc0), .frame_done_o(done0), .err_o(err0));

    window_frame_sequencer #(.FLUSH_LINES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .px_data_i(px_data), .px_data_val_i(px_val),
        .line_start_i(ls), .line_end_i(le), .frame_start_i(fs), .frame_end_i(fe),
        .in_ready_o(rdy1), .px_data_o(dat1), .px_data_val_o(val1),
        .line_start_o(ls1), .line_end_o(le1), .frame_start_o(fs1), .frame_end_o(fe1),
        .line_words_o(lw1), .line_cnt_o(lc1), .frame_done_o(done1), .err_o(err1));

    window_frame_sequencer #(.FLUSH_LINES(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .px_data_i(px_data), .px_data_val_i(px_val),
        .line_start_i(ls), .line_end_i(le), .frame_start_i(fs), .frame_end_i(fe),
        .in_ready_o(rdy2), .px_data_o(dat2), .px_data_val_o(val2),
        .line_start_o(ls2), .line_end_o(le2), .frame_start_o(fs2), .frame_end_o(fe2),
        .line_words_o(lw2), .line_cnt_o(lc2), .frame_done_o(done2), .err_o(err2));

    function automatic logic [47:0] px(input int n);
        return {12'(n + 3), 12'(n + 2), 12'(n + 1), 12'(n)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [47:0] d, input logic [3:0] v,
                       input logic s_l, input logic e_l, input logic s_f, input logic e_f);
        px_data = d; px_val = v; ls = s_l; le = e_l; fs = s_f; fe = e_f;
        step();
    endtask

    task automatic idle();
        put('0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        px_data = '0; px_val = '0; ls = 0; le = 0; fs = 0; fe = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        px_data = px(7); px_val = 4'hF; ls = 1; le = 0; fs = 1; fe = 0;
        rst = 1'b1;
        step();
        step();
        tests++;
        if ({rdy1, val1, ls1, le1, fs1, fe1, done1, err1} !== 11'b1_0000_000000 || dat1 !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b val=%h ls/le/fs/fe/done/err=%b%b%b%b%b%b dat=%h, expected rdy=1 rest 0",
                     rdy1, val1, ls1, le1, fs1, fe1, done1, err1, dat1);
        end
        tests++;
        if (lw1 !== '0 || lc1 !== '0 || rdy0 !== 1'b1 || rdy2 !== 1'b1) begin
            fails++;
            $display("FAIL reset_counters: got lw=%0d lc=%0d rdy0=%b rdy2=%b, expected 0 0 1 1", lw1, lc1, rdy0, rdy2);
        end
        rst = 1'b0;
        px_val = 4'h0; ls = 0; fs = 0;
        step();
    endtask

    task automatic test_basic();
        logic [9:0] exp_v;
        do_reset();
        for (int l = 0; l < 3; l++) begin
            for (int w = 0; w < 2; w++) begin
                put(px(l * 2 + w), 4'hF, w == 0, w == 1, (l == 0) && (w == 0), (l == 2) && (w == 1));
                exp_v = {!((l == 2) && (w == 1)), 4'hF, w == 0, w == 1, (l == 0) && (w == 0), 1'b0, 1'b0};
                tests++;
                if ({rdy1, val1, ls1, le1, fs1, fe1, done1} !== exp_v || dat1 !== px(l * 2 + w) || err1 !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_pass l%0d w%0d: got %b dat=%h err=%b, expected %b dat=%h err=0",
                             l, w, {rdy1, val1, ls1, le1, fs1, fe1, done1}, dat1, err1, exp_v, px(l * 2 + w));
                end
            end
        end
        tests++;
        if (lw1 !== 11'd2 || lc1 !== 16'd3) begin
            fails++;
            $display("FAIL basic_counts: got lw=%0d lc=%0d, expected 2 3", lw1, lc1);
        end
        for (int v = 2; v <= 8; v++) begin
            idle();
            exp_v = {v == 8, (v == 6 || v == 7) ? 4'hF : 4'h0, v == 6, v == 7, 1'b0, v == 7, v == 7};
            tests++;
            if ({rdy1, val1, ls1, le1, fs1, fe1, done1} !== exp_v || dat1 !== '0) begin
                fails++;
                $display("FAIL basic_flush v%0d: got %b dat=%h, expected %b dat=0",
                         v, {rdy1, val1, ls1, le1, fs1, fe1, done1}, dat1, exp_v);
            end
        end
    endtask

    task automatic test_multi_flush();
        logic [9:0] exp_v;
        do_reset();
        put(px(10), 4'hF, 1, 0, 1, 0);
        put(px(11), 4'b0011, 0, 1, 0, 1);
        tests++;
        if ({rdy2, val2, le2, fe2} !== 7'b0_0011_1_0 || lw2 !== 11'd2 || lc2 !== 16'd1) begin
            fails++;
            $display("FAIL multi_last_word: got rdy=%b val=%b le=%b fe=%b lw=%0d lc=%0d, expected 0 0011 1 0 2 1",
                     rdy2, val2, le2, fe2, lw2, lc2);
        end
        for (int v = 2; v <= 14; v++) begin
            idle();
            exp_v = {v == 14,
                     (v == 6 || v == 12) ? 4'hF : ((v == 7 || v == 13) ? 4'b0011 : 4'h0),
                     v == 6 || v == 12, v == 7 || v == 13, 1'b0, v == 13, v == 13};
            tests++;
            if ({rdy2, val2, ls2, le2, fs2, fe2, done2} !== exp_v || dat2 !== '0) begin
                fails++;
                $display("FAIL multi_flush v%0d: got %b dat=%h, expected %b dat=0",
                         v, {rdy2, val2, ls2, le2, fs2, fe2, done2}, dat2, exp_v);
            end
        end
    endtask

    task automatic test_no_flush();
        do_reset();
        put(px(20), 4'hF, 0, 0, 0, 0);
        tests++;
        if (val0 !== 4'h0 || err0 !== 1'b1 || rdy0 !== 1'b1) begin
            fails++;
            $display("FAIL idle_drop: got val=%h err=%b rdy=%b, expected 0 1 1", val0, err0, rdy0);
        end
        put(px(21), 4'hF, 1, 1, 1, 0);
        tests++;
        if ({rdy0, val0, ls0, le0, fs0, fe0, done0, err0} !== 11'b1_1111_111000 || dat0 !== px(21)) begin
            fails++;
            $display("FAIL noflush_first: got %b dat=%h, expected 11111111000 dat=%h",
                     {rdy0, val0, ls0, le0, fs0, fe0, done0, err0}, dat0, px(21));
        end
        put(px(22), 4'b0001, 1, 1, 0, 1);
        tests++;
        if ({rdy0, val0, ls0, le0, fs0, fe0, done0, err0} !== 11'b1_0001_110110 || dat0 !== px(22)) begin
            fails++;
            $display("FAIL noflush_end: got %b dat=%h, expected 10001110110 dat=%h",
                     {rdy0, val0, ls0, le0, fs0, fe0, done0, err0}, dat0, px(22));
        end
        tests++;
        if (lw0 !== 11'd1 || lc0 !== 16'd2) begin
            fails++;
            $display("FAIL noflush_counts: got lw=%0d lc=%0d, expected 1 2", lw0, lc0);
        end
        idle();
        tests++;
        if ({rdy0, val0, fe0, done0} !== 7'b1_0000_00 || lw0 !== 11'd1) begin
            fails++;
            $display("FAIL noflush_after: got rdy=%b val=%h fe=%b done=%b lw=%0d, expected 1 0 0 0 1",
                     rdy0, val0, fe0, done0, lw0);
        end
    endtask

    task automatic test_flush_violation();
        logic [10:0] exp_v;
        do_reset();
        put(px(30), 4'hF, 1, 0, 1, 0);
        put(px(31), 4'hF, 0, 1, 0, 1);
        for (int v = 2; v <= 9; v++) begin
            if (v <= 8) put(px(99), 4'hF, 1, 1, 1, 1);
            else idle();
            exp_v = {v >= 8, (v == 6 || v == 7) ? 4'hF : 4'h0, v == 6, v == 7, 1'b0, v == 7, v == 7, v <= 8};
            tests++;
            if ({rdy1, val1, ls1, le1, fs1, fe1, done1, err1} !== exp_v || dat1 !== '0) begin
                fails++;
                $display("FAIL flush_violation v%0d: got %b dat=%h, expected %b dat=0",
                         v, {rdy1, val1, ls1, le1, fs1, fe1, done1, err1}, dat1, exp_v);
            end
        end
    endtask

    task automatic test_restart();
        logic [9:0] exp_v;
        do_reset();
        put(px(40), 4'hF, 1, 0, 1, 0);
        put(px(41), 4'hF, 0, 0, 0, 0);
        put(px(42), 4'hF, 0, 1, 0, 0);
        tests++;
        if (lw1 !== 11'd3 || lc1 !== 16'd1 || err1 !== 1'b0) begin
            fails++;
            $display("FAIL restart_first_line: got lw=%0d lc=%0d err=%b, expected 3 1 0", lw1, lc1, err1);
        end
        put(px(43), 4'hF, 1, 0, 0, 0);
        put(px(44), 4'hF, 1, 0, 1, 0);
        tests++;
        if (err1 !== 1'b1 || fs1 !== 1'b1 || ls1 !== 1'b1 || lc1 !== 16'd0 || dat1 !== px(44)) begin
            fails++;
            $display("FAIL restart_fs: got err=%b fs=%b ls=%b lc=%0d dat=%h, expected 1 1 1 0 %h",
                     err1, fs1, ls1, lc1, dat1, px(44));
        end
        put(px(45), 4'b0111, 0, 1, 0, 1);
        tests++;
        if (lw1 !== 11'd2 || lc1 !== 16'd1 || err1 !== 1'b0 || rdy1 !== 1'b0) begin
            fails++;
            $display("FAIL restart_measure: got lw=%0d lc=%0d err=%b rdy=%b, expected 2 1 0 0", lw1, lc1, err1, rdy1);
        end
        for (int v = 2; v <= 8; v++) begin
            idle();
            exp_v = {v == 8, (v == 6) ? 4'hF : ((v == 7) ? 4'b0111 : 4'h0), v == 6, v == 7, 1'b0, v == 7, v == 7};
            tests++;
            if ({rdy1, val1, ls1, le1, fs1, fe1, done1} !== exp_v) begin
                fails++;
                $display("FAIL restart_flush v%0d: got %b, expected %b", v, {rdy1, val1, ls1, le1, fs1, fe1, done1}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [9:0] exp_v;
        do_reset();
        put(px(50), 4'hF, 1, 0, 1, 0);
        put(px(51), 4'hF, 0, 1, 0, 1);
        for (int v = 2; v <= 6; v++) idle();
        tests++;
        if (val1 !== 4'hF || ls1 !== 1'b1 || rdy1 !== 1'b0) begin
            fails++;
            $display("FAIL midflush_pad0: got val=%h ls=%b rdy=%b, expected f 1 0", val1, ls1, rdy1);
        end
        rst = 1'b1;
        idle();
        rst = 1'b0;
        tests++;
        if ({rdy1, val1, ls1, le1, fs1, fe1, done1, err1} !== 11'b1_0000_000000 || dat1 !== '0 ||
            lw1 !== '0 || lc1 !== '0) begin
            fails++;
            $display("FAIL midflush_reset: got %b dat=%h lw=%0d lc=%0d, expected 10000000000 0 0 0",
                     {rdy1, val1, ls1, le1, fs1, fe1, done1, err1}, dat1, lw1, lc1);
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            tests++;
            if ({rdy1, val1, fe1, done1} !== 7'b1_0000_00) begin
                fails++;
                $display("FAIL midflush_quiet k%0d: got rdy=%b val=%h fe=%b done=%b, expected 1 0 0 0",
                         k, rdy1, val1, fe1, done1);
            end
        end
        put(px(52), 4'b0001, 1, 1, 1, 1);
        tests++;
        if ({rdy1, val1, ls1, le1, fs1, fe1, done1} !== 10'b0_0001_11100 || lw1 !== 11'd1 || lc1 !== 16'd1) begin
            fails++;
            $display("FAIL midflush_next_frame: got %b lw=%0d lc=%0d, expected 0000111100 1 1",
                     {rdy1, val1, ls1, le1, fs1, fe1, done1}, lw1, lc1);
        end
        for (int v = 2; v <= 7; v++) begin
            idle();
            exp_v = {v == 7, (v == 6) ? 4'b0001 : 4'h0, v == 6, v == 6, 1'b0, v == 6, v == 6};
            tests++;
            if ({rdy1, val1, ls1, le1, fs1, fe1, done1} !== exp_v) begin
                fails++;
                $display("FAIL midflush_one_word_pad v%0d: got %b, expected %b",
                         v, {rdy1, val1, ls1, le1, fs1, fe1, done1}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_flush();
        test_no_flush();
        test_flush_violation();
        test_restart();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
